// File: rtl/bist_controller_if.sv
// rtl/bist_controller_if.sv - BIST controller handshake/status bundle (abort exists only with BIST_ABORT_EN)
interface bist_controller_if #(
    parameter int CNT_W     = 8,
    parameter int SIG_WIDTH = 16
);
    logic                 start;
`ifdef BIST_ABORT_EN
    logic                 abort;
`endif
    logic [SIG_WIDTH-1:0] misr_sig;
    logic [SIG_WIDTH-1:0] golden_sig;
    logic                 gen_rst;
    logic                 test_mode;
    logic                 misr_clr;
    logic                 misr_en;
    logic [CNT_W-1:0]     pat_cnt;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic                 fail;

    modport master (
`ifdef BIST_ABORT_EN
        input  abort,
`endif
        input  start, misr_sig, golden_sig,
        output gen_rst, test_mode, misr_clr, misr_en, pat_cnt, busy, done, pass, fail
    );

    modport slave (
`ifdef BIST_ABORT_EN
        output abort,
`endif
        output start, misr_sig, golden_sig,
        input  gen_rst, test_mode, misr_clr, misr_en, pat_cnt, busy, done, pass, fail
    );
endinterface

// File: rtl/bist_controller.sv
// rtl/bist_controller.sv - logic BIST run sequencer (seed, run, settle, check); abort under BIST_ABORT_EN
module bist_controller #(
    parameter int PATTERN_COUNT = 255,
    parameter int CNT_W         = 8,
    parameter int SIG_WIDTH     = 16
) (
    input  logic               clk,
    input  logic               rst,
    bist_controller_if.master  bif
);
    typedef enum logic [2:0] {IDLE, SEED, RUN, SETTLE, CHECK, DONE} state_t;

    // Compared against the pre-increment count, so PATTERN_COUNT = 2^CNT_W lands on all-ones.
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PATTERN_COUNT - 1);

    state_t           state, nxt;
    logic [CNT_W-1:0] pat_cnt;
    logic             gen_rst, test_mode, misr_clr, misr_en, busy, done, pass, fail;
    logic             sig_match;
    logic             abort_req;

`ifdef BIST_ABORT_EN
    assign abort_req = bif.abort;
`else
    assign abort_req = 1'b0;
`endif

    assign sig_match = (SIG_WIDTH'(bif.misr_sig) == SIG_WIDTH'(bif.golden_sig));

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (bif.start) nxt = SEED;
            SEED:    nxt = RUN;
            RUN:     if (pat_cnt == LAST) nxt = SETTLE;
            SETTLE:  nxt = CHECK;
            CHECK:   nxt = DONE;
            DONE:    if (bif.start) nxt = SEED;
            default: nxt = IDLE;
        endcase
        if (abort_req && (state inside {SEED, RUN, SETTLE, CHECK}))
            nxt = IDLE;
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pat_cnt   <= '0;
            gen_rst   <= 1'b1;
            test_mode <= 1'b0;
            misr_clr  <= 1'b0;
            misr_en   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
        end else begin
            state     <= nxt;
            gen_rst   <= (nxt inside {IDLE, SEED, DONE});
            test_mode <= (nxt inside {SEED, RUN, SETTLE, CHECK});
            busy      <= (nxt inside {SEED, RUN, SETTLE, CHECK});
            misr_clr  <= (nxt == SEED);
            misr_en   <= (nxt == RUN);
            done      <= (nxt == DONE);

            if (nxt == SEED)
                pat_cnt <= '0;
            else if (state == RUN)
                pat_cnt <= pat_cnt + CNT_W'(1);

            // Verdict is cleared as soon as DONE is left, so it is only ever visible in DONE.
            if (state == CHECK && nxt == DONE) begin
                pass <= sig_match;
                fail <= !sig_match;
            end else if (nxt != DONE) begin
                pass <= 1'b0;
                fail <= 1'b0;
            end
        end
    end

    assign bif.gen_rst   = gen_rst;
    assign bif.test_mode = test_mode;
    assign bif.misr_clr  = misr_clr;
    assign bif.misr_en   = misr_en;
    assign bif.pat_cnt   = pat_cnt;
    assign bif.busy      = busy;
    assign bif.done      = done;
    assign bif.pass      = pass;
    assign bif.fail      = fail;
endmodule

// File: tb/tb_bist_controller.sv
// tb/tb_bist_controller.sv - directed bench for bist_controller (255-pattern and 1-pattern instances)
module tb_bist_controller;
    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    bist_controller_if #(.CNT_W(8), .SIG_WIDTH(16)) a_if ();
    bist_controller_if #(.CNT_W(8), .SIG_WIDTH(16)) b_if ();

    bist_controller #(.PATTERN_COUNT(255), .CNT_W(8), .SIG_WIDTH(16)) dut_a (
        .clk(clk), .rst(rst), .bif(a_if.master));
    bist_controller #(.PATTERN_COUNT(1), .CNT_W(8), .SIG_WIDTH(16)) dut_b (
        .clk(clk), .rst(rst), .bif(b_if.master));

    // {gen_rst, test_mode, misr_clr, misr_en, busy, done, pass, fail}
    localparam logic [7:0] ST_IDLE  = 8'b1000_0000;
    localparam logic [7:0] ST_SEED  = 8'b1110_1000;
    localparam logic [7:0] ST_PASS  = 8'b1000_0110;
    localparam logic [7:0] ST_FAILV = 8'b1000_0101;

    function automatic logic [7:0] st(input bit which);
        if (which)
            return {b_if.gen_rst, b_if.test_mode, b_if.misr_clr, b_if.misr_en,
                    b_if.busy, b_if.done, b_if.pass, b_if.fail};
        return {a_if.gen_rst, a_if.test_mode, a_if.misr_clr, a_if.misr_en,
                a_if.busy, a_if.done, a_if.pass, a_if.fail};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs from just after SEED until done is seen; reports misr_en cycles and
    // the cycle gap from the last misr_en to done. poke pulses start mid-RUN.
    task automatic measure(input bit which, input bit poke,
                           output int en_cnt, output int gap, output bit bad);
        logic [7:0] s;
        int last_en = -1;
        int done_i  = -1;
        en_cnt = 0;
        bad    = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (poke) a_if.start = (i == 10);
            s = st(which);
            if (s[1] && s[0]) bad = 1'b1;
            if ((s[1] || s[0]) && !s[2]) bad = 1'b1;
            if (s[4]) begin en_cnt++; last_en = i; end
            if (s[2]) begin done_i = i; break; end
        end
        gap = (done_i < 0 || last_en < 0) ? -1 : done_i - last_en;
    endtask

    task automatic wait_cnt(input logic [7:0] target, output bit found);
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (a_if.pat_cnt == target && a_if.misr_en) begin found = 1'b1; break; end
        end
    endtask

    int en_cnt, gap;
    bit bad, found;

    initial begin
        rst = 1'b1;
        a_if.start = 1'b0; a_if.misr_sig = 16'hA5C3; a_if.golden_sig = 16'hA5C3;
        b_if.start = 1'b0; b_if.misr_sig = 16'h1234; b_if.golden_sig = 16'h1234;
`ifdef BIST_ABORT_EN
        a_if.abort = 1'b0;
        b_if.abort = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("reset_status", 32'(st(0)), 32'(ST_IDLE));
        check("reset_pat_cnt", 32'(a_if.pat_cnt), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_hold", 32'(st(0)), 32'(ST_IDLE));

        // Passing run with a one-cycle start pulse
        a_if.start = 1'b1;
        @(negedge clk);
        a_if.start = 1'b0;
        check("run1_seed", 32'(st(0)), 32'(ST_SEED));
        measure(0, 0, en_cnt, gap, bad);
        check("run1_en_cycles", 32'(en_cnt), 32'd255);
        check("run1_done_gap", 32'(gap), 32'd3);
        check("run1_verdict_only_in_done", 32'(bad), 32'd0);
        check("run1_done_status", 32'(st(0)), 32'(ST_PASS));
        check("run1_pat_cnt", 32'(a_if.pat_cnt), 32'd255);
        @(negedge clk);
        check("run1_done_hold", 32'(st(0)), 32'(ST_PASS));

        // Failing signature, with a stray start pulse during RUN
        a_if.golden_sig = 16'hA5C2;
        a_if.start = 1'b1;
        @(negedge clk);
        a_if.start = 1'b0;
        check("run2_seed_clears", 32'(st(0)), 32'(ST_SEED));
        measure(0, 1, en_cnt, gap, bad);
        check("run2_en_cycles", 32'(en_cnt), 32'd255);
        check("run2_done_gap", 32'(gap), 32'd3);
        check("run2_verdict_only_in_done", 32'(bad), 32'd0);
        check("run2_done_status", 32'(st(0)), 32'(ST_FAILV));

        // Level-held start from DONE: back-to-back runs with one DONE cycle
        a_if.golden_sig = 16'hA5C3;
        a_if.start = 1'b1;
        @(negedge clk);
        check("run3_seed_from_done", 32'(st(0)), 32'(ST_SEED));
        measure(0, 0, en_cnt, gap, bad);
        check("run3_en_cycles", 32'(en_cnt), 32'd255);
        check("run3_done_status", 32'(st(0)), 32'(ST_PASS));
        @(negedge clk);
        check("run4_seed_back_to_back", 32'(st(0)), 32'(ST_SEED));
        a_if.start = 1'b0;

        // Reset on the 100th RUN cycle, with start also high
        wait_cnt(8'd99, found);
        check("run4_reached_cycle100", 32'(found), 32'd1);
        rst = 1'b1;
        a_if.start = 1'b1;
        @(negedge clk);
        check("midrun_reset_status", 32'(st(0)), 32'(ST_IDLE));
        check("midrun_reset_pat_cnt", 32'(a_if.pat_cnt), 32'd0);
        rst = 1'b0;
        a_if.start = 1'b0;
        @(negedge clk);
        check("post_reset_idle", 32'(st(0)), 32'(ST_IDLE));

        // Single-pattern instance
        b_if.start = 1'b1;
        @(negedge clk);
        b_if.start = 1'b0;
        check("pc1_seed", 32'(st(1)), 32'(ST_SEED));
        measure(1, 0, en_cnt, gap, bad);
        check("pc1_en_cycles", 32'(en_cnt), 32'd1);
        check("pc1_done_gap", 32'(gap), 32'd3);
        check("pc1_done_status", 32'(st(1)), 32'(ST_PASS));
        check("pc1_pat_cnt", 32'(b_if.pat_cnt), 32'd1);

`ifdef BIST_ABORT_EN
        a_if.start = 1'b1;
        @(negedge clk);
        a_if.start = 1'b0;
        wait_cnt(8'd50, found);
        check("abort_reached_cnt50", 32'(found), 32'd1);
        a_if.abort = 1'b1;
        @(negedge clk);
        a_if.abort = 1'b0;
        check("abort_status", 32'(st(0)), 32'(ST_IDLE));
        @(negedge clk);
        check("abort_stays_idle", 32'(st(0)), 32'(ST_IDLE));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
